// File: rtl/sys_ctrl_cmd.sv
// Command-frame controller: decodes the 0xAA/0xBB/0xCC/0xDD byte protocol from UART RX,
// drives register-file and ALU strobes, and returns read/ALU result bytes to the TX FIFO.
module sys_ctrl_cmd #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int width_fun  = 4
) (
    input  logic                      REF_CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]     Address,
    output logic                      WrEn,
    output logic                      RdEn,
    output logic [DATA_WIDTH-1:0]     WrData,
    input  logic [DATA_WIDTH-1:0]     RdData,
    input  logic                      RdData_Valid,
    output logic [width_fun-1:0]      ALU_FUN,
    output logic                      ALU_EN,
    output logic                      CLK_EN,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      OUT_VALID,
    input  logic                      FIFO_FULL,
    output logic [DATA_WIDTH-1:0]     FIFO_WR_DATA,
    output logic                      FIFO_WR_INC
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        ALU_A,
        ALU_B,
        ALU_FN,
        ALU_WAIT,
        TX_RD,
        TX_LSB,
        TX_MSB
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0]   rd_q;
    logic [2*DATA_WIDTH-1:0] alu_q;

    logic [ADDR_WIDTH-1:0]   address_nxt;
    logic                    wr_en_nxt;
    logic                    rd_en_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_nxt;
    logic [width_fun-1:0]    alu_fun_nxt;
    logic                    alu_en_nxt;
    logic                    clk_en_nxt;
    logic [DATA_WIDTH-1:0]   fifo_data_nxt;
    logic                    fifo_inc_nxt;

    // State register plus the captured read / ALU results
    always_ff @(posedge REF_CLK) begin
        if (RST) begin
            state <= IDLE;
            rd_q  <= '0;
            alu_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == RD_WAIT && RdData_Valid) begin
                rd_q <= RdData;
            end
            if (state == ALU_WAIT && OUT_VALID) begin
                alu_q <= ALU_OUT;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:      state_nxt = WR_ADDR;
                        CMD_RD:      state_nxt = RD_ADDR;
                        CMD_ALU_OP:  state_nxt = ALU_A;
                        CMD_ALU_NOP: state_nxt = ALU_FN;
                        default:     state_nxt = IDLE;
                    endcase
                end
            end
            WR_ADDR:  if (RX_D_VLD)     state_nxt = WR_DATA;
            WR_DATA:  if (RX_D_VLD)     state_nxt = IDLE;
            RD_ADDR:  if (RX_D_VLD)     state_nxt = RD_WAIT;
            RD_WAIT:  if (RdData_Valid) state_nxt = TX_RD;
            ALU_A:    if (RX_D_VLD)     state_nxt = ALU_B;
            ALU_B:    if (RX_D_VLD)     state_nxt = ALU_FN;
            ALU_FN:   if (RX_D_VLD)     state_nxt = ALU_WAIT;
            ALU_WAIT: if (OUT_VALID)    state_nxt = TX_LSB;
            TX_RD:    if (!FIFO_FULL)   state_nxt = IDLE;
            TX_LSB:   if (!FIFO_FULL)   state_nxt = TX_MSB;
            TX_MSB:   if (!FIFO_FULL)   state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Output logic computes next-cycle values; every output is then registered below
    always_comb begin
        address_nxt   = Address;
        wr_en_nxt     = 1'b0;
        rd_en_nxt     = 1'b0;
        wr_data_nxt   = WrData;
        alu_fun_nxt   = ALU_FUN;
        alu_en_nxt    = 1'b0;
        clk_en_nxt    = CLK_EN;
        fifo_data_nxt = FIFO_WR_DATA;
        fifo_inc_nxt  = 1'b0;
        case (state)
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    address_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_nxt   = 1'b1;
                    wr_data_nxt = RX_P_DATA;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_en_nxt   = 1'b1;
                    address_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
                end
            end
            ALU_A: begin
                if (RX_D_VLD) begin
                    wr_en_nxt   = 1'b1;
                    address_nxt = '0;
                    wr_data_nxt = RX_P_DATA;
                end
            end
            ALU_B: begin
                if (RX_D_VLD) begin
                    wr_en_nxt   = 1'b1;
                    address_nxt = ADDR_WIDTH'(1);
                    wr_data_nxt = RX_P_DATA;
                end
            end
            ALU_FN: begin
                if (RX_D_VLD) begin
                    alu_fun_nxt = RX_P_DATA[width_fun-1:0];
                    alu_en_nxt  = 1'b1;
                    clk_en_nxt  = 1'b1;
                end
            end
            ALU_WAIT: begin
                if (OUT_VALID) begin
                    clk_en_nxt = 1'b0;
                end
            end
            TX_RD: begin
                if (!FIFO_FULL) begin
                    fifo_inc_nxt  = 1'b1;
                    fifo_data_nxt = rd_q;
                end
            end
            TX_LSB: begin
                if (!FIFO_FULL) begin
                    fifo_inc_nxt  = 1'b1;
                    fifo_data_nxt = alu_q[DATA_WIDTH-1:0];
                end
            end
            TX_MSB: begin
                if (!FIFO_FULL) begin
                    fifo_inc_nxt  = 1'b1;
                    fifo_data_nxt = alu_q[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge REF_CLK) begin
        if (RST) begin
            Address      <= '0;
            WrEn         <= 1'b0;
            RdEn         <= 1'b0;
            WrData       <= '0;
            ALU_FUN      <= '0;
            ALU_EN       <= 1'b0;
            CLK_EN       <= 1'b0;
            FIFO_WR_DATA <= '0;
            FIFO_WR_INC  <= 1'b0;
        end else begin
            Address      <= address_nxt;
            WrEn         <= wr_en_nxt;
            RdEn         <= rd_en_nxt;
            WrData       <= wr_data_nxt;
            ALU_FUN      <= alu_fun_nxt;
            ALU_EN       <= alu_en_nxt;
            CLK_EN       <= clk_en_nxt;
            FIFO_WR_DATA <= fifo_data_nxt;
            FIFO_WR_INC  <= fifo_inc_nxt;
        end
    end

endmodule

// File: tb/tb_sys_ctrl_cmd.sv
// Self-checking bench for sys_ctrl_cmd: frame-level reference model checked every cycle,
// directed protocol scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_sys_ctrl_cmd;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;

    logic            REF_CLK = 1'b0;
    logic            RST;
    logic [DW-1:0]   RX_P_DATA;
    logic            RX_D_VLD;
    logic [AW-1:0]   Address;
    logic            WrEn, RdEn;
    logic [DW-1:0]   WrData, RdData;
    logic            RdData_Valid;
    logic [FW-1:0]   ALU_FUN;
    logic            ALU_EN, CLK_EN;
    logic [2*DW-1:0] ALU_OUT;
    logic            OUT_VALID, FIFO_FULL;
    logic [DW-1:0]   FIFO_WR_DATA;
    logic            FIFO_WR_INC;

    sys_ctrl_cmd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .width_fun(FW)) dut (
        .REF_CLK(REF_CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .RdData(RdData),
        .RdData_Valid(RdData_Valid), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_EN(CLK_EN),
        .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .FIFO_FULL(FIFO_FULL),
        .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_INC(FIFO_WR_INC)
    );

    always #5 REF_CLK = ~REF_CLK;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    // Reference model: collected frame bytes, pending response kind, bytes owed to the FIFO
    logic [7:0]  frame[$];
    int          wait_kind = 0;   // 0 none, 1 read data, 2 ALU result
    logic [7:0]  tx_q[$];
    logic [AW-1:0] e_addr;
    logic [7:0]  e_wdata, e_fdata;
    logic [FW-1:0] e_fun;
    logic        e_wren, e_rden, e_aluen, e_clken, e_finc;
    logic        fun_chk = 1'b0;
    logic        rst_seen = 1'b0;

    // Observation logs for the directed literal checks
    logic [11:0] wr_log[$];
    logic [3:0]  rd_log[$];
    logic [3:0]  alu_log[$];
    logic [7:0]  push_log[$];
    int unsigned push_cyc[$];
    int          clk_cnt = 0;

    // Responder configuration
    logic        rand_mode = 1'b0;
    int unsigned rd_delay = 1, alu_delay = 2;
    logic [7:0]  rd_val = 8'h00;
    logic [15:0] alu_val = 16'h0000;
    logic        resp_is_rd;
    int unsigned resp_d;
    logic [7:0]  cmds[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic start_alu(input logic [7:0] fb);
        e_fun    = fb[FW-1:0];
        e_aluen  = 1'b1;
        e_clken  = 1'b1;
        fun_chk  = 1'b1;
        wait_kind = 2;
        frame.delete();
    endtask

    task automatic model_step();
        logic [7:0] b1, b2;
        e_wren = 1'b0; e_rden = 1'b0; e_aluen = 1'b0; e_finc = 1'b0;
        rst_seen = RST;
        if (RST) begin
            frame.delete(); tx_q.delete(); wait_kind = 0;
            e_addr = '0; e_wdata = '0; e_fdata = '0; e_fun = '0; e_clken = 1'b0; fun_chk = 1'b0;
        end else if (tx_q.size() > 0) begin
            if (!FIFO_FULL) begin
                e_fdata = tx_q.pop_front();
                e_finc  = 1'b1;
                if (tx_q.size() == 0) fun_chk = 1'b0;
            end
        end else if (wait_kind == 1) begin
            if (RdData_Valid) begin
                tx_q.push_back(RdData);
                wait_kind = 0;
            end
        end else if (wait_kind == 2) begin
            if (OUT_VALID) begin
                tx_q.push_back(ALU_OUT[7:0]);
                tx_q.push_back(ALU_OUT[15:8]);
                e_clken = 1'b0;
                wait_kind = 0;
            end
        end else if (RX_D_VLD) begin
            frame.push_back(RX_P_DATA);
            b1 = (frame.size() > 1) ? frame[1] : 8'h00;
            b2 = (frame.size() > 2) ? frame[2] : 8'h00;
            case (frame[0])
                8'hAA: if (frame.size() == 3) begin
                    e_wren = 1'b1; e_addr = b1[AW-1:0]; e_wdata = b2; frame.delete();
                end
                8'hBB: if (frame.size() == 2) begin
                    e_rden = 1'b1; e_addr = b1[AW-1:0]; wait_kind = 1; frame.delete();
                end
                8'hCC: begin
                    if (frame.size() == 2) begin
                        e_wren = 1'b1; e_addr = '0; e_wdata = b1;
                    end else if (frame.size() == 3) begin
                        e_wren = 1'b1; e_addr = AW'(1); e_wdata = b2;
                    end else if (frame.size() == 4) begin
                        start_alu(frame[3]);
                    end
                end
                8'hDD: if (frame.size() == 2) start_alu(b1);
                default: frame.delete();
            endcase
        end
    endtask

    task automatic check();
        if (rst_seen)
            chk("reset_outputs", 32'({Address, WrEn, RdEn, WrData, ALU_FUN, ALU_EN, CLK_EN,
                                     FIFO_WR_DATA, FIFO_WR_INC}), 32'd0);
        chk("wren", 32'(WrEn), 32'(e_wren));
        chk("rden", 32'(RdEn), 32'(e_rden));
        chk("alu_en", 32'(ALU_EN), 32'(e_aluen));
        chk("clk_en", 32'(CLK_EN), 32'(e_clken));
        chk("fifo_inc", 32'(FIFO_WR_INC), 32'(e_finc));
        chk("wr_rd_exclusive", 32'(WrEn & RdEn), 32'd0);
        if (e_wren || e_rden) chk("address", 32'(Address), 32'(e_addr));
        if (e_wren) chk("wrdata", 32'(WrData), 32'(e_wdata));
        if (fun_chk) chk("alu_fun", 32'(ALU_FUN), 32'(e_fun));
        if (e_finc) chk("fifo_data", 32'(FIFO_WR_DATA), 32'(e_fdata));
        if (WrEn) wr_log.push_back({Address, WrData});
        if (RdEn) rd_log.push_back(Address);
        if (ALU_EN) alu_log.push_back(ALU_FUN);
        if (CLK_EN) clk_cnt++;
        if (FIFO_WR_INC) begin
            push_log.push_back(FIFO_WR_DATA);
            push_cyc.push_back(cyc);
        end
    endtask

    always @(posedge REF_CLK) begin
        model_step();
        #1;
        check();
        cyc++;
    end

    // Register-file / ALU responder: answers each RdEn / ALU_EN with a delayed valid pulse
    initial begin
        RdData_Valid = 1'b0; OUT_VALID = 1'b0; RdData = '0; ALU_OUT = '0;
        forever begin
            @(posedge REF_CLK); #2;
            if (RdEn || ALU_EN) begin
                resp_is_rd = RdEn;
                resp_d = rand_mode ? $urandom_range(0, 4) : (RdEn ? rd_delay : alu_delay);
                repeat (resp_d + 1) @(negedge REF_CLK);
                if (resp_is_rd) begin
                    RdData = rand_mode ? 8'($urandom) : rd_val;
                    RdData_Valid = 1'b1;
                end else begin
                    ALU_OUT = rand_mode ? 16'($urandom) : alu_val;
                    OUT_VALID = 1'b1;
                end
                @(negedge REF_CLK);
                RdData_Valid = 1'b0; OUT_VALID = 1'b0;
                RdData = 8'($urandom); ALU_OUT = 16'($urandom);
            end else if (rand_mode && $urandom_range(0, 7) == 0) begin
                @(negedge REF_CLK);
                RdData = 8'($urandom); ALU_OUT = 16'($urandom);
                RdData_Valid = 1'($urandom_range(0, 1));
                OUT_VALID = 1'($urandom_range(0, 1));
                @(negedge REF_CLK);
                RdData_Valid = 1'b0; OUT_VALID = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b; RX_D_VLD = 1'b1;
        @(negedge REF_CLK);
        RX_D_VLD = 1'b0; RX_P_DATA = 8'($urandom);
    endtask

    task automatic wait_idle(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (!(wait_kind == 0 && tx_q.size() == 0) && n < budget) begin
            @(negedge REF_CLK);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
        repeat (2) @(negedge REF_CLK);
    endtask

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); alu_log.delete();
        push_log.delete(); push_cyc.delete(); clk_cnt = 0;
    endtask

    initial begin
        RST = 1'b1; RX_D_VLD = 1'b0; RX_P_DATA = '0; FIFO_FULL = 1'b0;
        repeat (3) @(negedge REF_CLK);
        RST = 1'b0;

        // Plain register write
        clear_logs();
        send(8'hAA); send(8'h05); send(8'h69);
        repeat (3) @(negedge REF_CLK);
        chk("t1_wr_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() > 0) chk("t1_wr_addr_data", 32'(wr_log[0]), 32'h569);
        chk("t1_rd_count", 32'(rd_log.size()), 32'd0);
        chk("t1_alu_count", 32'(alu_log.size()), 32'd0);
        chk("t1_push_count", 32'(push_log.size()), 32'd0);

        // Register read returned through the FIFO
        clear_logs();
        rd_val = 8'h69; rd_delay = 1;
        send(8'hBB); send(8'h05);
        wait_idle("t2_timeout", 50);
        chk("t2_rd_count", 32'(rd_log.size()), 32'd1);
        if (rd_log.size() > 0) chk("t2_rd_addr", 32'(rd_log[0]), 32'h5);
        chk("t2_push_count", 32'(push_log.size()), 32'd1);
        if (push_log.size() > 0) chk("t2_push_data", 32'(push_log[0]), 32'h69);

        // ALU with operands
        clear_logs();
        alu_val = 16'h000D; alu_delay = 2;
        send(8'hCC); send(8'h0A); send(8'h03); send(8'h00);
        wait_idle("t3_timeout", 50);
        chk("t3_wr_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() > 1) begin
            chk("t3_wr_op_a", 32'(wr_log[0]), 32'h00A);
            chk("t3_wr_op_b", 32'(wr_log[1]), 32'h103);
        end
        chk("t3_alu_count", 32'(alu_log.size()), 32'd1);
        if (alu_log.size() > 0) chk("t3_alu_fun", 32'(alu_log[0]), 32'h0);
        chk("t3_clk_en_cycles", 32'(clk_cnt), 32'd3);
        chk("t3_push_count", 32'(push_log.size()), 32'd2);
        if (push_log.size() > 1) begin
            chk("t3_push_lsb", 32'(push_log[0]), 32'h0D);
            chk("t3_push_msb", 32'(push_log[1]), 32'h00);
        end

        // ALU without operands, FIFO full stall
        clear_logs();
        alu_val = 16'h0007; FIFO_FULL = 1'b1;
        send(8'hDD); send(8'h01);
        repeat (8) @(negedge REF_CLK);
        chk("t4_no_push_while_full", 32'(push_log.size()), 32'd0);
        FIFO_FULL = 1'b0;
        wait_idle("t4_timeout", 50);
        chk("t4_push_count", 32'(push_log.size()), 32'd2);
        if (push_log.size() > 1) begin
            chk("t4_push_lsb", 32'(push_log[0]), 32'h07);
            chk("t4_push_msb", 32'(push_log[1]), 32'h00);
            chk("t4_push_consecutive", push_cyc[1] - push_cyc[0], 32'd1);
        end
        if (alu_log.size() > 0) chk("t4_alu_fun", 32'(alu_log[0]), 32'h1);

        // Ignored bytes, then a normal write still works
        clear_logs();
        rd_val = 8'hC3; rd_delay = 4;
        send(8'h55); send(8'hBB); send(8'h03); send(8'h11);
        wait_idle("t5_timeout", 50);
        send(8'hAA); send(8'h02); send(8'h33);
        repeat (3) @(negedge REF_CLK);
        chk("t5_rd_count", 32'(rd_log.size()), 32'd1);
        chk("t5_alu_count", 32'(alu_log.size()), 32'd0);
        chk("t5_wr_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() > 0) chk("t5_wr_addr_data", 32'(wr_log[0]), 32'h233);
        if (push_log.size() > 0) chk("t5_push_data", 32'(push_log[0]), 32'hC3);

        // Reset aborts a partial write frame
        clear_logs();
        send(8'hAA); send(8'h04);
        RST = 1'b1;
        @(negedge REF_CLK);
        RST = 1'b0;
        chk("t6_outputs_zero", 32'({Address, WrEn, RdEn, WrData, ALU_FUN, ALU_EN, CLK_EN,
                                   FIFO_WR_DATA, FIFO_WR_INC}), 32'd0);
        send(8'h77);
        repeat (4) @(negedge REF_CLK);
        chk("t6_wr_count", 32'(wr_log.size()), 32'd0);

        // Randomized traffic with resets, stalls and stray valid pulses
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            RST = ($urandom_range(0, 199) == 0);
            RX_D_VLD = ($urandom_range(0, 2) == 0);
            RX_P_DATA = ($urandom_range(0, 9) < 4) ? cmds[$urandom_range(0, 3)] : 8'($urandom);
            FIFO_FULL = ($urandom_range(0, 3) == 0);
            @(negedge REF_CLK);
        end
        RST = 1'b0; RX_D_VLD = 1'b0; FIFO_FULL = 1'b0;
        wait_idle("rand_drain_timeout", 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
